// File: rtl/addsub_arbiter.sv
// Round-robin front end that shares one combinational add/sub datapath between two requesters.
// Optional overflow event counter: define ADDSUB_OVF_CNT_EN to add the ovf_cnt port.
module addsub_arbiter #(
  parameter int WIDTH = 16
`ifdef ADDSUB_OVF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_add,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_ovf,
  output logic [WIDTH-1:0]   dp_a,
  output logic [WIDTH-1:0]   dp_b,
  output logic               dp_add,
  input  logic [WIDTH-1:0]   dp_sum,
  input  logic               dp_cout,
  input  logic               dp_ovf
`ifdef ADDSUB_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0]   ovf_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_add;
  logic             op_id;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = ~last_grant;
    end else if (req_valid == 2'b10) begin
      grant = 1'b1;
    end
  end

  assign accept    = (state == IDLE) && (req_valid != 2'b00);
  assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state == RESP);

  assign dp_a   = op_a;
  assign dp_b   = op_b;
  assign dp_add = op_add;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_add     <= 1'b0;
      op_id      <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a       <= grant ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
        op_b       <= grant ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
        op_add     <= grant ? req_add[1] : req_add[0];
        op_id      <= grant;
        last_grant <= grant;
      end
      // The datapath result is captured once, at the end of the single EXEC cycle.
      if (state == EXEC) begin
        rsp_id   <= op_id;
        rsp_sum  <= dp_sum;
        rsp_cout <= dp_cout;
        rsp_ovf  <= dp_ovf;
      end
    end
  end

`ifdef ADDSUB_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if ((state == EXEC) && dp_ovf && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter; a behavioural 16-bit add/sub stands in for the datapath.
module tb_addsub_arbiter;

  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]        req_add;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [WIDTH-1:0]  rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;
  logic [WIDTH-1:0]  dp_a;
  logic [WIDTH-1:0]  dp_b;
  logic              dp_add;
  logic [WIDTH-1:0]  dp_sum;
  logic              dp_cout;
  logic              dp_ovf;
  logic [WIDTH:0]    dp_full;
`ifdef ADDSUB_OVF_CNT_EN
  logic [15:0]       ovf_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0]  valid;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        add0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        add1;
    logic        rdy;
    logic [1:0]  exp_rr;
    logic        exp_rv;
    logic        exp_id;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_add(req_add),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout),
    .rsp_ovf(rsp_ovf),
    .dp_a(dp_a),
    .dp_b(dp_b),
    .dp_add(dp_add),
    .dp_sum(dp_sum),
    .dp_cout(dp_cout),
    .dp_ovf(dp_ovf)
`ifdef ADDSUB_OVF_CNT_EN
    ,
    .ovf_cnt(ovf_cnt)
`endif
  );

  // Stand-in for adder_16bit_s: subtraction is A + ~B + 1, O is two's-complement overflow.
  always_comb begin
    if (dp_add) begin
      dp_full = {1'b0, dp_a} + {1'b0, dp_b};
    end else begin
      dp_full = {1'b0, dp_a} + {1'b0, ~dp_b} + 17'd1;
    end
    dp_sum  = dp_full[WIDTH-1:0];
    dp_cout = dp_full[WIDTH];
    if (dp_add) begin
      dp_ovf = (dp_a[15] == dp_b[15]) && (dp_sum[15] != dp_a[15]);
    end else begin
      dp_ovf = (dp_a[15] != dp_b[15]) && (dp_sum[15] != dp_a[15]);
    end
  end

  function automatic vec_t mkVec(logic [1:0] valid, logic [15:0] a0, logic [15:0] b0, logic add0,
                                 logic [15:0] a1, logic [15:0] b1, logic add1, logic rdy,
                                 logic [1:0] rr, logic rv, logic id, logic [15:0] sum,
                                 logic cout, logic ovf);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.b0 = b0; v.add0 = add0;
    v.a1 = a1; v.b1 = b1; v.add1 = add1; v.rdy = rdy;
    v.exp_rr = rr; v.exp_rv = rv; v.exp_id = id; v.exp_sum = sum;
    v.exp_cout = cout; v.exp_ovf = ovf;
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    req_valid = v.valid;
    req_a     = {v.a1, v.a0};
    req_b     = {v.b1, v.b0};
    req_add   = {v.add1, v.add0};
    rsp_ready = v.rdy;
  endtask

  task automatic checkOutput(string name, logic [1:0] rr, logic rv, logic chk_data,
                             logic id, logic [15:0] sum, logic cout, logic ovf);
    cmp({name, ".req_ready"}, {30'd0, req_ready}, {30'd0, rr});
    cmp({name, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, rv});
    if (chk_data) begin
      cmp({name, ".rsp_id"}, {31'd0, rsp_id}, {31'd0, id});
      cmp({name, ".rsp_sum"}, {16'd0, rsp_sum}, {16'd0, sum});
      cmp({name, ".rsp_cout"}, {31'd0, rsp_cout}, {31'd0, cout});
      cmp({name, ".rsp_ovf"}, {31'd0, rsp_ovf}, {31'd0, ovf});
    end
  endtask

  task automatic checkDp(string name, logic [15:0] a, logic [15:0] b, logic add);
    cmp({name, ".dp_a"}, {16'd0, dp_a}, {16'd0, a});
    cmp({name, ".dp_b"}, {16'd0, dp_b}, {16'd0, b});
    cmp({name, ".dp_add"}, {31'd0, dp_add}, {31'd0, add});
  endtask

  // Single-requester op with a bounded wait for the response; expects the 2-edge latency.
  task automatic runOp(string name, logic id, logic [15:0] a, logic [15:0] b, logic add,
                       logic [15:0] sum, logic cout, logic ovf);
    int waited;
    rsp_ready = 1'b1;
    req_valid = id ? 2'b10 : 2'b01;
    req_a     = {a, a};
    req_b     = {b, b};
    req_add   = {add, add};
    #1;
    cmp({name, ".accept"}, {30'd0, req_ready}, {30'd0, (id ? 2'b10 : 2'b01)});
    @(negedge clk);
    req_valid = 2'b00;
    waited = 0;
    while (!rsp_valid && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    cmp({name, ".latency"}, waited, 1);
    checkOutput(name, 2'b00, 1'b1, 1'b1, id, sum, cout, ovf);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    vecs[0]  = mkVec(2'b01, 16'h7FFF, 16'h0001, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[1]  = mkVec(2'b00, 16'h7FFF, 16'h0001, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[2]  = mkVec(2'b00, 16'h7FFF, 16'h0001, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[3]  = mkVec(2'b10, 16'h0000, 16'h0000, 1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[4]  = mkVec(2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vecs[5]  = mkVec(2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    for (int i = 6; i < 18; i++) begin
      case ((i - 6) % 6)
        0: vecs[i] = mkVec(2'b11, 16'h1234, 16'h1111, 1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        2: vecs[i] = mkVec(2'b11, 16'h1234, 16'h1111, 1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'h2345, 1'b0, 1'b0);
        3: vecs[i] = mkVec(2'b11, 16'h1234, 16'h1111, 1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        5: vecs[i] = mkVec(2'b11, 16'h1234, 16'h1111, 1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        default: vecs[i] = mkVec(2'b11, 16'h1234, 16'h1111, 1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      endcase
    end

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_add   = 2'b00;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset", 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkDp("reset", 16'h0000, 16'h0000, 1'b0);
`ifdef ADDSUB_OVF_CNT_EN
    cmp("reset.ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_rr, vecs[i].exp_rv, vecs[i].exp_rv,
                  vecs[i].exp_id, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
      @(negedge clk);
    end

    // Back-pressure: result must hold and no request may be accepted while rsp_ready is low.
    req_valid = 2'b01;
    req_a     = {16'h0005, 16'hFFFF};
    req_b     = {16'h0003, 16'h0001};
    req_add   = 2'b01;
    rsp_ready = 1'b0;
    #1;
    checkOutput("bp_accept", 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    checkOutput("bp_exec", 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkDp("bp_exec", 16'hFFFF, 16'h0001, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("bp_hold%0d", k), 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_handshake", 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("bp_resume", 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("bp_rsp1", 2'b00, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    @(negedge clk);

    // Reset while an op from requester 0 is in EXEC; afterwards requester 0 must win a tie again.
    req_valid = 2'b01;
    req_a     = {16'h0000, 16'h4000};
    req_b     = {16'h0000, 16'h4000};
    req_add   = 2'b01;
    #1;
    checkOutput("rst_accept", 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid", 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkDp("rst_mid", 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_norsp%0d", k), 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    end
    req_valid = 2'b11;
    req_a     = {16'h0003, 16'h1234};
    req_b     = {16'h0005, 16'h1111};
    req_add   = 2'b01;
    #1;
    checkOutput("rst_tie", 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("rst_rsp", 2'b00, 1'b1, 1'b1, 1'b0, 16'h2345, 1'b0, 1'b0);
    @(negedge clk);

    // Three overflowing subtractions and one clean add.
    runOp("ovf0", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    runOp("ovf1", 1'b0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    runOp("ovf2", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    runOp("clean", 1'b0, 16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b0);
`ifdef ADDSUB_OVF_CNT_EN
    cmp("ovf_cnt", {16'd0, ovf_cnt}, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
